morse_rx: RTL and testbench
===========================

# morse_rx

Morse-code receiver for the TinyFPGA BX. It runs in the CLK domain and reads a push-button on a user pin. It debounces the button, times each press and gap, classifies each press as a dot or a dash, and presents each completed symbol with a one-cycle valid strobe. It is the input-side counterpart of the LED pattern blinker: a human keys Morse into the board instead of the board flashing it out.

## Interface
Parameters:
- TICK_DIV, 16000: CLK cycles per timing tick (1 ms at 16 MHz).
- DEBOUNCE_TICKS, 20: consecutive stable ticks required to accept a level change.
- DASH_TICKS, 200: a press lasting this many ticks or more is a dash; a shorter press is a dot.
- LETTER_GAP_TICKS, 600: release time, in ticks, that terminates a symbol.

Ports:
- CLK  in  1  16 MHz system clock.
- RST  in  1  synchronous, active-high reset.
- BTN  in  1  raw button, active-high, asynchronous to CLK.
- LED  out  1  debounced button level (echo).
- USBPU  out  1  tied 0 (USB disabled).
- sym_valid  out  1  one-cycle strobe: a symbol is complete.
- sym_bits  out  6  element pattern, 1 = dash, first element in bit 0, unused bits 0.
- sym_len  out  3  element count, 1..6.
- sym_err  out  1  symbol exceeded 6 elements.
- ascii  out  8  decoded character (see Configuration).

## Operation
- Synchronizer: BTN passes through two flops before any other use.
- Prescaler: a counter over 0..TICK_DIV-1 produces a one-cycle `tick` when it wraps.
- Debouncer: a counter increments on each tick while the synchronized input differs from the debounced level, and clears whenever the two agree. When the counter reaches DEBOUNCE_TICKS, the debounced level flips and the counter clears. The block emits one-cycle rise/fall events on each flip.
- Duration counter: 10 bits, increments on each tick, saturates at 1023, clears on every state transition.
- FSM states:
  - IDLE: released, no elements held. On rise → PRESS.
  - PRESS: counts press time. On fall → GAP. At the fall, append an element: dash if count ≥ DASH_TICKS, else dot. The element goes to bit index len, and len increments. If len is already 6, set the overflow flag instead and leave bits and len unchanged.
  - GAP: counts release time. On rise → PRESS. When count reaches LETTER_GAP_TICKS → IDLE. On that transition, register the symbol outputs, pulse sym_valid, then clear the working bits, len and overflow flag.
- sym_bits, sym_len, sym_err and ascii hold their values until the next emission.
- A rise and a gap timeout in the same cycle: the timeout wins. The symbol is emitted and the FSM enters PRESS directly, starting a new symbol.
- Reset values: all outputs 0, FSM in IDLE, debounced level 0, all counters 0.
- Reset asserted mid-symbol discards the partial symbol; nothing is emitted.

## Timing
- BTN edge to debounced edge: 2 cycles of synchronization, then DEBOUNCE_TICKS ticks, +1 cycle.
- Debounced fall to sym_valid: LETTER_GAP_TICKS ticks (measurement granularity is ±1 tick), +1 cycle.
- sym_valid is high for exactly 1 CLK cycle. All symbol outputs are valid in that same cycle.
- Gap and press thresholds use ≥ comparisons against the tick count since the state was entered.
- Presses beyond 1023 ticks saturate the counter and still classify as a dash.

## Configuration
- MORSE_ASCII_EN defined: a registered lookup maps (sym_bits, sym_len) to ASCII, updated in the same cycle as the symbol outputs.
  - Covers A–Z (uppercase) and 0–9.
  - Any unmapped pattern, or sym_err=1, yields 8'h3F ('?').
- MORSE_ASCII_EN undefined: ascii is constant 8'h00 and no lookup logic is synthesized.

## Test plan
All scenarios use TICK_DIV=4, DEBOUNCE_TICKS=2, DASH_TICKS=10, LETTER_GAP_TICKS=30, with MORSE_ASCII_EN defined unless noted.
- Three presses of 4 ticks each, 8-tick gaps, then release → one sym_valid, sym_bits=6'b000000, sym_len=3, sym_err=0, ascii=8'h53 ('S').
- Three 15-tick presses → sym_bits=6'b000111, sym_len=3, ascii=8'h4F ('O'). With MORSE_ASCII_EN undefined, ascii=8'h00.
- Threshold boundary: a 10-tick press → bits=6'b000001, len=1, ascii=8'h54 ('T'). A 9-tick press → bits=6'b000000, len=1, ascii=8'h45 ('E').
- BTN glitch high for 1 tick, and bouncing at 1-tick intervals for 5 ticks → LED stays 0, no sym_valid.
- Seven dot presses → sym_err=1, sym_len=6, sym_bits=6'b000000, ascii=8'h3F.
- RST pulsed mid-PRESS after two dots → no sym_valid. A following "E" (one dot) then emits len=1, ascii=8'h45.

Source files
------------

// File: rtl/morse_rx_if.sv
// Symbol output bus of the Morse receiver: one-cycle valid strobe plus held symbol fields.
interface morse_rx_if;
    logic       sym_valid;
    logic [5:0] sym_bits;
    logic [2:0] sym_len;
    logic       sym_err;
    logic [7:0] ascii;

    modport master (output sym_valid, sym_bits, sym_len, sym_err, ascii);
    modport slave  (input  sym_valid, sym_bits, sym_len, sym_err, ascii);
endinterface

// File: rtl/morse_rx.sv
// Morse receiver: sync + debounce a button, time presses/gaps, emit dot/dash symbols.
// Define MORSE_ASCII_EN to add a registered (bits,len)->ASCII lookup; otherwise ascii is 0.
module morse_rx #(
    parameter int TICK_DIV         = 16000,
    parameter int DEBOUNCE_TICKS   = 20,
    parameter int DASH_TICKS       = 200,
    parameter int LETTER_GAP_TICKS = 600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    output logic       LED,
    output logic       USBPU,
    morse_rx_if.master sym
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

    logic          r_sync1, r_sync2;
    logic [PW-1:0] r_pre;
    logic          w_tick;
    logic [DW-1:0] r_dbcnt;
    logic          r_deb, r_rise, r_fall;
    state_t        r_state, w_next;
    logic [9:0]    r_dur;
    logic          w_emit, w_append;
    logic [5:0]    r_bits;
    logic [2:0]    r_len;
    logic          r_ovf;
    logic          r_sym_valid, r_sym_err;
    logic [5:0]    r_sym_bits;
    logic [2:0]    r_sym_len;

    assign w_tick = (r_pre == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_pre   <= '0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
        end
    end

    // Counter only advances while the input disagrees; any agreement restarts it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dbcnt <= '0;
            r_deb   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync2 == r_deb) begin
                r_dbcnt <= '0;
            end else if (w_tick) begin
                if (r_dbcnt == DW'(DEBOUNCE_TICKS - 1)) begin
                    r_deb   <= ~r_deb;
                    r_dbcnt <= '0;
                    r_rise  <= ~r_deb;
                    r_fall  <= r_deb;
                end else begin
                    r_dbcnt <= r_dbcnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_emit   = 1'b0;
        w_append = 1'b0;
        case (r_state)
            S_IDLE:  if (r_rise) w_next = S_PRESS;
            S_PRESS: if (r_fall) begin
                w_next   = S_GAP;
                w_append = 1'b1;
            end
            S_GAP: begin
                // Timeout beats a simultaneous rise; the rise then opens the next symbol.
                if (int'(r_dur) >= LETTER_GAP_TICKS) begin
                    w_emit = 1'b1;
                    w_next = r_rise ? S_PRESS : S_IDLE;
                end else if (r_rise) begin
                    w_next = S_PRESS;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_dur   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_dur <= '0;
            else if (w_tick && r_dur != 10'h3FF)
                r_dur <= r_dur + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bits <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_emit) begin
            r_bits <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_append) begin
            if (r_len == 3'd6) begin
                r_ovf <= 1'b1;
            end else begin
                r_bits[r_len] <= (int'(r_dur) >= DASH_TICKS);
                r_len         <= r_len + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sym_valid <= 1'b0;
            r_sym_bits  <= '0;
            r_sym_len   <= '0;
            r_sym_err   <= 1'b0;
        end else begin
            r_sym_valid <= w_emit;
            if (w_emit) begin
                r_sym_bits <= r_bits;
                r_sym_len  <= r_len;
                r_sym_err  <= r_ovf;
            end
        end
    end

`ifdef MORSE_ASCII_EN
    // Element pattern is LSB-first, 1 = dash.
    function automatic logic [7:0] f_ascii(input logic [2:0] len, input logic [5:0] bits);
        case ({len, bits})
            {3'd2, 6'd2}:  f_ascii = "A";   {3'd4, 6'd1}:  f_ascii = "B";
            {3'd4, 6'd5}:  f_ascii = "C";   {3'd3, 6'd1}:  f_ascii = "D";
            {3'd1, 6'd0}:  f_ascii = "E";   {3'd4, 6'd4}:  f_ascii = "F";
            {3'd3, 6'd3}:  f_ascii = "G";   {3'd4, 6'd0}:  f_ascii = "H";
            {3'd2, 6'd0}:  f_ascii = "I";   {3'd4, 6'd14}: f_ascii = "J";
            {3'd3, 6'd5}:  f_ascii = "K";   {3'd4, 6'd2}:  f_ascii = "L";
            {3'd2, 6'd3}:  f_ascii = "M";   {3'd2, 6'd1}:  f_ascii = "N";
            {3'd3, 6'd7}:  f_ascii = "O";   {3'd4, 6'd6}:  f_ascii = "P";
            {3'd4, 6'd11}: f_ascii = "Q";   {3'd3, 6'd2}:  f_ascii = "R";
            {3'd3, 6'd0}:  f_ascii = "S";   {3'd1, 6'd1}:  f_ascii = "T";
            {3'd3, 6'd4}:  f_ascii = "U";   {3'd4, 6'd8}:  f_ascii = "V";
            {3'd3, 6'd6}:  f_ascii = "W";   {3'd4, 6'd9}:  f_ascii = "X";
            {3'd4, 6'd13}: f_ascii = "Y";   {3'd4, 6'd3}:  f_ascii = "Z";
            {3'd5, 6'd31}: f_ascii = "0";   {3'd5, 6'd30}: f_ascii = "1";
            {3'd5, 6'd28}: f_ascii = "2";   {3'd5, 6'd24}: f_ascii = "3";
            {3'd5, 6'd16}: f_ascii = "4";   {3'd5, 6'd0}:  f_ascii = "5";
            {3'd5, 6'd1}:  f_ascii = "6";   {3'd5, 6'd3}:  f_ascii = "7";
            {3'd5, 6'd7}:  f_ascii = "8";   {3'd5, 6'd15}: f_ascii = "9";
            default:       f_ascii = 8'h3F;
        endcase
    endfunction

    logic [7:0] r_ascii;
    always_ff @(posedge CLK) begin
        if (RST)
            r_ascii <= 8'h00;
        else if (w_emit)
            r_ascii <= r_ovf ? 8'h3F : f_ascii(r_len, r_bits);
    end
    assign sym.ascii = r_ascii;
`else
    assign sym.ascii = 8'h00;
`endif

    assign sym.sym_valid = r_sym_valid;
    assign sym.sym_bits  = r_sym_bits;
    assign sym.sym_len   = r_sym_len;
    assign sym.sym_err   = r_sym_err;
    assign LED           = r_deb;
    assign USBPU         = 1'b0;
endmodule

// File: tb/tb_morse_rx.sv
// Randomized scoreboard bench for morse_rx: keyed symbols are modelled from the Morse table.
module tb_morse_rx;
    localparam int TD = 4, DB = 2, DT = 10, GT = 30;

    logic CLK = 1'b0;
    logic RST, BTN, LED, USBPU;
    morse_rx_if sif();

    morse_rx #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .DASH_TICKS(DT), .LETTER_GAP_TICKS(GT)) dut (
        .CLK(CLK), .RST(RST), .BTN(BTN), .LED(LED), .USBPU(USBPU), .sym(sif));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] bits;
        logic [2:0] len;
        logic       err;
        logic [7:0] ascii;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0, n_chk = 0;
    bit   quiet = 0;
    int   quiet_viol = 0;
    bit   prev_v = 0;

    string tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                        "---..", "----."};

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: truncate to six elements, flag overflow, look the dot/dash string up.
    function automatic exp_t model(input bit el[$]);
        exp_t  e;
        string s = "";
        e.err   = (el.size() > 6);
        e.len   = 3'((el.size() > 6) ? 6 : el.size());
        e.bits  = '0;
        e.ascii = 8'h00;
        for (int i = 0; i < el.size(); i++) begin
            if (i < 6) e.bits[i] = el[i];
            s = {s, el[i] ? "-" : "."};
        end
`ifdef MORSE_ASCII_EN
        e.ascii = 8'h3F;
        if (!e.err)
            for (int i = 0; i < 36; i++)
                if (tab[i] == s) e.ascii = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
`endif
        return e;
    endfunction

    task automatic idle(input int t);
        repeat (t * TD) @(negedge CLK);
    endtask

    task automatic press(input int t);
        BTN = 1'b1;
        idle(t);
        BTN = 1'b0;
    endtask

    // Durations of 0 mean "pick at random, clear of the dot/dash threshold".
    task automatic send(input bit el[$], input int dot_t, input int dash_t, input int gap_t);
        for (int i = 0; i < el.size(); i++) begin
            if (el[i]) press(dash_t > 0 ? dash_t : int'($urandom_range(20, 12)));
            else       press(dot_t  > 0 ? dot_t  : int'($urandom_range(7, 3)));
            if (i == el.size() - 1) sb.push_back(model(el));
            else idle(gap_t > 0 ? gap_t : int'($urandom_range(15, 5)));
        end
        idle(GT + 15);
    endtask

    always @(negedge CLK) begin
        if (quiet && (LED || sif.sym_valid)) quiet_viol++;
        if (prev_v) check("valid_width", int'(sif.sym_valid), 0);
        prev_v = sif.sym_valid;
        if (sif.sym_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_sym", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bits",  int'(sif.sym_bits), int'(e.bits));
                check("len",   int'(sif.sym_len),  int'(e.len));
                check("err",   int'(sif.sym_err),  int'(e.err));
                check("ascii", int'(sif.ascii),    int'(e.ascii));
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, int'(sif.sym_valid), 0);
        check({tag, "_bits"},  int'(sif.sym_bits),  0);
        check({tag, "_len"},   int'(sif.sym_len),   0);
        check({tag, "_err"},   int'(sif.sym_err),   0);
        check({tag, "_ascii"}, int'(sif.ascii),     0);
        check({tag, "_led"},   int'(LED),           0);
        check({tag, "_usbpu"}, int'(USBPU),         0);
    endtask

    initial begin
        bit el[$];
        int wait_cyc;
        RST = 1'b1;
        BTN = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        check_cleared("reset");

        el = '{0, 0, 0};       send(el, 4, 0, 8);     // S
        el = '{1, 1, 1};       send(el, 0, 15, 0);    // O
        el = '{1};             send(el, 0, DT, 0);    // T at the dash threshold
        el = '{0};             send(el, DT - 1, 0, 0);// E just below it
        el = '{1};             send(el, 0, 1100, 0);  // saturated press is still a dash

        // Single-tick glitch and 1-tick bouncing must never get through.
        quiet = 1;
        press(1);
        idle(4);
        for (int k = 0; k < 5; k++) begin
            BTN = (k % 2 == 0);
            idle(1);
        end
        BTN = 1'b0;
        idle(GT + 10);
        quiet = 0;
        check("glitch_quiet", quiet_viol, 0);

        el = '{0, 0, 0, 0, 0, 0, 0};  send(el, 0, 0, 0);   // overflow

        // Reset in the middle of the third press throws away the partial symbol.
        press(4); idle(8); press(4); idle(8);
        BTN = 1'b1;
        idle(5);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        BTN = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check_cleared("midreset");
        quiet_viol = 0;
        quiet = 1;
        idle(GT + 15);
        quiet = 0;
        check("midreset_quiet", quiet_viol, 0);
        el = '{0};             send(el, 0, 0, 0);    // E

        for (int n = 0; n < 20; n++) begin
            el.delete();
            if (n % 2 == 0) begin
                string s;
                s = tab[$urandom_range(35, 0)];
                for (int j = 0; j < s.len(); j++) el.push_back(s[j] == "-");
            end else begin
                int k;
                k = $urandom_range(7, 1);
                for (int j = 0; j < k; j++) el.push_back(1'($urandom_range(1, 0)));
            end
            send(el, 0, 0, 0);
        end

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 1000) begin
            @(negedge CLK);
            wait_cyc++;
        end
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
